// File: rtl/arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Holds the FSM encoding, the round-robin requester id and the tie-break rule.
package arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CORE   = 2'd1,
    INJ_RD = 2'd2,
    INJ_WR = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_INJ  = 1'b1
  } req_id_t;

  // On a tie the requester that was not served last wins; a lone requester always wins.
  function automatic req_id_t pick_winner(input logic core_req, input logic inj_req,
                                          input req_id_t last_gnt);
    req_id_t win;
    if (core_req && inj_req) begin
      win = (last_gnt == REQ_INJ) ? REQ_CORE : REQ_INJ;
    end else if (core_req) begin
      win = REQ_CORE;
    end else begin
      win = REQ_INJ;
    end
    return win;
  endfunction

endpackage

// File: rtl/dmem_fault_arbiter.sv
// Shares one data-memory port between the core load/store path and the fault
// injector; injections run as an indivisible read-modify-write XOR bit-flip.
module dmem_fault_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_a,
  input  logic [DATA_W-1:0] core_wd,
  output logic              core_gnt,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              inj_req,
  input  logic [ADDR_W-1:0] inj_a,
  input  logic [DATA_W-1:0] inj_mask,
  output logic              inj_done,
  output logic [CNT_W-1:0]  inj_count,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_t        state_r;
  arb_state_t        state_nxt_s;
  req_id_t           last_gnt_r;
  logic [DATA_W-1:0] rmw_r;
  logic [DATA_W-1:0] core_rdata_r;
  logic              core_rvalid_r;
  logic [CNT_W-1:0]  inj_count_r;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_a_s;
  logic [DATA_W-1:0] mem_wd_s;
  logic              core_load_s;

  assign core_load_s = (state_r == CORE) && !core_we;

  // Next-state selection and memory-port muxing from the registered state.
  always_comb begin
    state_nxt_s = state_r;
    mem_we_s    = 1'b0;
    mem_a_s     = '0;
    mem_wd_s    = '0;
    case (state_r)
      IDLE: begin
        if (core_req || inj_req) begin
          if (pick_winner(core_req, inj_req, last_gnt_r) == REQ_CORE) begin
            state_nxt_s = CORE;
          end else begin
            state_nxt_s = INJ_RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CORE: begin
        mem_a_s     = core_a;
        mem_we_s    = core_we;
        mem_wd_s    = core_wd;
        state_nxt_s = IDLE;
      end
      INJ_RD: begin
        mem_a_s     = inj_a;
        state_nxt_s = INJ_WR;
      end
      INJ_WR: begin
        mem_a_s     = inj_a;
        mem_we_s    = 1'b1;
        mem_wd_s    = rmw_r ^ inj_mask;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, round-robin bit, RMW capture, load data and saturating injection count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      last_gnt_r    <= REQ_INJ;
      rmw_r         <= '0;
      core_rdata_r  <= '0;
      core_rvalid_r <= 1'b0;
      inj_count_r   <= '0;
    end else begin
      state_r       <= state_nxt_s;
      core_rvalid_r <= core_load_s;
      if (core_load_s) begin
        core_rdata_r <= mem_rd;
      end
      if (state_r == INJ_RD) begin
        rmw_r <= mem_rd;
      end
      if (state_r == CORE) begin
        last_gnt_r <= REQ_CORE;
      end else if (state_r == INJ_WR) begin
        last_gnt_r <= REQ_INJ;
      end
      // Counting happens on the write cycle, so an aborted read phase never counts.
      if ((state_r == INJ_WR) && (inj_count_r != CNT_MAX)) begin
        inj_count_r <= inj_count_r + CNT_ONE;
      end
    end
  end

  assign core_gnt    = (state_r == CORE);
  assign inj_done    = (state_r == INJ_WR);
  assign core_rdata  = core_rdata_r;
  assign core_rvalid = core_rvalid_r;
  assign inj_count   = inj_count_r;
  assign mem_we      = mem_we_s;
  assign mem_a       = mem_a_s;
  assign mem_wd      = mem_wd_s;

endmodule

// File: tb/tb_dmem_fault_arbiter.sv
// Self-checking bench: a transaction-level memory/arbitration model is compared
// against the arbiter driving a behavioural combinational-read memory.
module tb_dmem_fault_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we;
  logic [AW-1:0] core_a;
  logic [DW-1:0] core_wd;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          inj_req;
  logic [AW-1:0] inj_a;
  logic [DW-1:0] inj_mask;
  logic          inj_done;
  logic [CW-1:0] inj_count;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;

  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;
  logic [DW-1:0] mem [0:255];

  logic [DW-1:0] ref_mem [0:255];
  logic          last_core;
  logic [CW-1:0] cnt_model;
  int            vectors;
  int            miscompares;

  always #5 clk = ~clk;

  dmem_fault_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_a(core_a), .core_wd(core_wd),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .inj_req(inj_req), .inj_a(inj_a), .inj_mask(inj_mask),
    .inj_done(inj_done), .inj_count(inj_count),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
    else if (pre_we) mem[pre_a] <= pre_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    tick();
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0; core_req = 1'b0; inj_req = 1'b0;
    tick();
    tick();
    vectors++;
    if ({core_gnt, core_rvalid, core_rdata, inj_done, inj_count, mem_we, mem_a, mem_wd} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: gnt=%b rvalid=%b rdata=%h done=%b cnt=%h we=%b a=%h wd=%h, required all 0",
               core_gnt, core_rvalid, core_rdata, inj_done, inj_count, mem_we, mem_a, mem_wd);
    end
    rst = 1'b1;
    last_core = 1'b0;
    cnt_model = '0;
  endtask

  task automatic core_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    core_req = 1'b1; core_we = we; core_a = a; core_wd = wd;
    tick();
    vectors++;
    if (core_gnt !== 1'b1 || inj_done !== 1'b0) begin
      miscompares++;
      $display("FAIL core_gnt: gnt=%b inj_done=%b, required gnt=1 inj_done=0", core_gnt, inj_done);
    end
    vectors++;
    if (mem_we !== we || mem_a !== a || (we && mem_wd !== wd)) begin
      miscompares++;
      $display("FAIL core_port: we=%b a=%h wd=%h, required we=%b a=%h wd=%h", mem_we, mem_a, mem_wd, we, a, wd);
    end
    core_req = 1'b0;
    if (we) ref_mem[a] = wd;
    last_core = 1'b1;
    tick();
    vectors++;
    if (core_rvalid !== ~we || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL core_after: rvalid=%b mem_we=%b, required rvalid=%b mem_we=0", core_rvalid, mem_we, ~we);
    end
    if (!we) begin
      vectors++;
      if (core_rdata !== ref_mem[a]) begin
        miscompares++;
        $display("FAIL core_rdata: addr=%h got %h, required %h", a, core_rdata, ref_mem[a]);
      end
    end
  endtask

  task automatic inj_access(input logic [AW-1:0] a, input logic [DW-1:0] mask);
    inj_req = 1'b1; inj_a = a; inj_mask = mask;
    tick();
    vectors++;
    if (mem_a !== a || mem_we !== 1'b0 || inj_done !== 1'b0 || core_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL inj_rd: a=%h we=%b done=%b gnt=%b, required a=%h we=0 done=0 gnt=0",
               mem_a, mem_we, inj_done, core_gnt, a);
    end
    tick();
    vectors++;
    if (inj_done !== 1'b1 || mem_we !== 1'b1 || mem_a !== a || mem_wd !== (ref_mem[a] ^ mask)) begin
      miscompares++;
      $display("FAIL inj_wr: done=%b we=%b a=%h wd=%h, required done=1 we=1 a=%h wd=%h",
               inj_done, mem_we, mem_a, mem_wd, a, ref_mem[a] ^ mask);
    end
    inj_req = 1'b0;
    ref_mem[a] = ref_mem[a] ^ mask;
    if (cnt_model != 4'hF) cnt_model = cnt_model + 4'd1;
    last_core = 1'b0;
    tick();
    vectors++;
    if (inj_count !== cnt_model || inj_done !== 1'b0) begin
      miscompares++;
      $display("FAIL inj_count: cnt=%h done=%b, required cnt=%h done=0", inj_count, inj_done, cnt_model);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_first_load();
    rst = 1'b0;
    preload(8'd28, 32'h0000_0020);
    do_reset();
    core_access(1'b0, 8'd28, 32'h0);
    vectors++;
    if (core_rdata !== 32'h0000_0020) begin
      miscompares++;
      $display("FAIL first_load: got %h, required 00000020", core_rdata);
    end
  endtask

  task automatic test_inject();
    inj_access(8'd28, 32'h1);
    vectors++;
    if (inj_count !== 4'd1) begin
      miscompares++;
      $display("FAIL inject_count: got %h, required 1", inj_count);
    end
    core_access(1'b0, 8'd28, 32'h0);
    vectors++;
    if (core_rdata !== 32'h0000_0021) begin
      miscompares++;
      $display("FAIL inject_readback: got %h, required 00000021", core_rdata);
    end
  endtask

  task automatic test_contention();
    logic order[$];
    logic prev_rd;
    logic [DW-1:0] mask;
    mask = $urandom;
    do_reset();
    core_req = 1'b1; core_we = 1'b0; core_a = 8'd10; core_wd = '0;
    inj_req = 1'b1; inj_a = 8'd20; inj_mask = mask;
    prev_rd = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if ((core_gnt && inj_done) || (prev_rd && !inj_done)) begin
        miscompares++;
        $display("FAIL contention_overlap: cycle=%0d gnt=%b done=%b prev_rd=%b", c + 1, core_gnt, inj_done, prev_rd);
      end
      if (core_gnt) begin
        order.push_back(1'b1);
        last_core = 1'b1;
      end
      if (inj_done) begin
        order.push_back(1'b0);
        ref_mem[20] = ref_mem[20] ^ mask;
        if (cnt_model != 4'hF) cnt_model = cnt_model + 4'd1;
        last_core = 1'b0;
      end
      prev_rd = (mem_a == 8'd20) && !mem_we && !core_gnt && !inj_done;
    end
    core_req = 1'b0; inj_req = 1'b0;
    tick();
    vectors++;
    if (order.size() != 4) begin
      miscompares++;
      $display("FAIL contention_count: got %0d grants, required 4", order.size());
    end
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      vectors++;
      if (order[k] !== ((k % 2) == 0)) begin
        miscompares++;
        $display("FAIL contention_order: grant %0d core=%b, required core=%b", k, order[k], (k % 2) == 0);
      end
    end
    vectors++;
    if (inj_count !== cnt_model) begin
      miscompares++;
      $display("FAIL contention_cnt: got %h, required %h", inj_count, cnt_model);
    end
    core_access(1'b0, 8'd20, 32'h0);
  endtask

  task automatic test_reset_mid_inj();
    logic saw_we;
    saw_we = 1'b0;
    inj_req = 1'b1; inj_a = 8'd5; inj_mask = 32'hFFFF_0001;
    tick();
    rst = 1'b0;
    inj_req = 1'b0;
    #1;
    vectors++;
    if ({core_gnt, core_rvalid, core_rdata, inj_done, inj_count, mem_we, mem_a, mem_wd} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: gnt=%b rvalid=%b rdata=%h done=%b cnt=%h we=%b a=%h wd=%h, required all 0",
               core_gnt, core_rvalid, core_rdata, inj_done, inj_count, mem_we, mem_a, mem_wd);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (mem_we) saw_we = 1'b1;
    end
    vectors++;
    if (saw_we !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_we: mem_we seen=%b, required 0", saw_we);
    end
    rst = 1'b1;
    last_core = 1'b0;
    cnt_model = '0;
    core_access(1'b0, 8'd5, 32'h0);
    vectors++;
    if (inj_count !== 4'd0) begin
      miscompares++;
      $display("FAIL midreset_cnt: got %h, required 0", inj_count);
    end
  endtask

  task automatic test_saturation();
    logic [AW-1:0] addrs[$];
    do_reset();
    for (int i = 0; i < 17; i++) begin
      addrs.push_back(8'($urandom));
      inj_access(addrs[i], 32'h0);
    end
    vectors++;
    if (inj_count !== 4'hF) begin
      miscompares++;
      $display("FAIL saturation: got %h, required f", inj_count);
    end
    for (int i = 0; i < 4; i++) core_access(1'b0, addrs[i], 32'h0);
  endtask

  task automatic test_store();
    core_access(1'b1, 8'd3, 32'hDEAD_BEEF);
    core_access(1'b0, 8'd3, 32'h0);
    vectors++;
    if (core_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL store_readback: got %h, required deadbeef", core_rdata);
    end
  endtask

  task automatic test_random();
    logic          we;
    logic [AW-1:0] ca, ia;
    logic [DW-1:0] wd, mk;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom);
      ca = 8'($urandom_range(0, 15));
      ia = 8'($urandom_range(0, 15));
      wd = $urandom;
      mk = $urandom;
      case ($urandom_range(0, 2))
        0: core_access(we, ca, wd);
        1: inj_access(ia, mk);
        default: begin
          core_req = 1'b1; core_we = we; core_a = ca; core_wd = wd;
          inj_req = 1'b1; inj_a = ia; inj_mask = mk;
          if (last_core) begin
            inj_access(ia, mk);
            core_access(we, ca, wd);
          end else begin
            core_access(we, ca, wd);
            inj_access(ia, mk);
          end
        end
      endcase
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; core_req = 1'b0; core_we = 1'b0; core_a = '0; core_wd = '0;
    inj_req = 1'b0; inj_a = '0; inj_mask = '0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    last_core = 1'b0; cnt_model = '0;
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    test_reset();
    test_first_load();
    test_inject();
    test_store();
    test_contention();
    test_reset_mid_inj();
    test_saturation();
    do_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_fault_arbiter.md
# dmem_fault_arbiter

Two-requester arbiter and sequencer for the data memory port of the golden core. It shares the single memory port between the core load/store path and the fault injector. Core accesses are single-cycle; injector requests run as an indivisible read-modify-write bit-flip (`mem[A] ^= mask`). The block sits between the core and the data memory, drives the memory's `WE/A/WD` and samples its combinational `RD`.

## Interface
Parameters:
- `ADDR_W`, 32: address width, passed unmodified to memory (word index).
- `DATA_W`, 32: data width.
- `CNT_W`, 16: injection counter width.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `core_req`  in  1: core access request; level, held until `core_gnt`.
- `core_we`  in  1: 1 = store, 0 = load; stable while `core_req`.
- `core_a`  in  ADDR_W: core address.
- `core_wd`  in  DATA_W: store data.
- `core_gnt`  out  1: one-cycle pulse; the core access is on the memory port this cycle.
- `core_rdata`  out  DATA_W: registered load data.
- `core_rvalid`  out  1: one-cycle pulse, cycle after a load grant.
- `inj_req`  in  1: injection request; level, held until `inj_done`.
- `inj_a`  in  ADDR_W: target address.
- `inj_mask`  in  DATA_W: XOR flip mask.
- `inj_done`  out  1: one-cycle pulse in the write cycle of the RMW.
- `inj_count`  out  CNT_W: completed injections, saturating.
- `mem_we`  out  1: memory write enable.
- `mem_a`  out  ADDR_W: memory address.
- `mem_wd`  out  DATA_W: memory write data.
- `mem_rd`  in  DATA_W: memory combinational read data.

## Operation
- FSM states: `IDLE`, `CORE`, `INJ_RD`, `INJ_WR`.
- `IDLE`: memory outputs are 0 (`mem_we=0`).
  - Only `core_req` asserted → `CORE`.
  - Only `inj_req` asserted → `INJ_RD`.
  - Both asserted → grant the requester not in `last_gnt`.
  - Neither asserted → stay.
- `CORE`:
  - Drive `mem_a=core_a`, `mem_we=core_we`, `mem_wd=core_wd`.
  - Assert `core_gnt`, set `last_gnt=CORE`.
  - If load: `core_rdata<=mem_rd`, and `core_rvalid` pulses next cycle.
  - Next state `IDLE`.
- `INJ_RD`: drive `mem_a=inj_a`, `mem_we=0`; capture `rmw_q<=mem_rd`; next state `INJ_WR`.
- `INJ_WR`:
  - Drive `mem_a=inj_a`, `mem_we=1`, `mem_wd=rmw_q ^ inj_mask`.
  - Assert `inj_done`, set `last_gnt=INJ`.
  - `inj_count` increments unless at all-ones.
  - Next state `IDLE`.
- The RMW is indivisible. A `core_req` arriving during `INJ_RD/INJ_WR` waits.
- `mask=0` still performs the full RMW (rewrites the same data) and is counted.
- `core_rdata` holds its last value until the next load; it is not cleared by stores.
- A requester dropping `req` before its grant is legal; the arbiter simply sees no request. Inputs are sampled only in `IDLE` and in the granted state.

## Timing
- Reset (async, `rst=0`):
  - state=`IDLE`, `last_gnt=INJ` (core wins the first tie).
  - All outputs 0: `core_gnt`, `core_rvalid`, `core_rdata`, `inj_done`, `inj_count`, `mem_we`, `mem_a`, `mem_wd`.
- Reset mid-operation:
  - In `INJ_RD`: no write occurs and the count is unchanged.
  - In `INJ_WR` or `CORE`: the write is suppressed immediately because `mem_we` is forced to 0.
- Core load: request visible in `IDLE` at cycle N → `core_gnt` at N+1 → `core_rvalid`/`core_rdata` at N+2.
- Core store: `core_gnt` and the memory write both occur at N+1.
- Injection: request at N → read at N+1 → write and `inj_done` at N+2; `inj_count` updates at N+3.
- Every grant returns to `IDLE`, giving one bubble cycle. Sustained single-requester throughput is:
  - core: 1 access per 2 cycles;
  - injector: 1 injection per 3 cycles.
- Under continuous contention, grants strictly alternate CORE, INJ, CORE, ...
- All outputs are decoded from registered state only; there are no combinational input→output paths except memory-port muxing of the `*_a/*_wd` inputs.

## Structure
- Shared package `arb_pkg`:
  - `arb_state_t` enum (`IDLE`, `CORE`, `INJ_RD`, `INJ_WR`);
  - `req_id_t` enum (`REQ_CORE`, `REQ_INJ`);
  - parameter defaults.
- No sub-module. The FSM, the 2-way round-robin bit, the RMW data register and the saturating counter sit in one flat module.

## Test plan
- Reset release, `core_req=1`, `core_we=0`, `core_a=28`, mem[28]=0x20 → `core_gnt` at cycle 1, `core_rvalid=1` with `core_rdata=0x00000020` at cycle 2.
- `inj_req`, `inj_a=28`, `inj_mask=0x1` with mem[28]=0x20 → `INJ_WR` writes 0x21, `inj_done` once, `inj_count=1`; a following core load of 28 returns 0x21.
- `core_req` and `inj_req` held together for 10 cycles from reset → grant order CORE, INJ, CORE, INJ; no grant overlaps; RMW cycles are never split by `core_gnt`.
- `rst` pulled low during `INJ_RD` of an injection to address 5 → `mem_we` never 1, mem[5] unchanged, `inj_count` unchanged, all outputs 0.
- `CNT_W=4`, 17 injections with `mask=0` → `inj_count` stops at 0xF; memory contents unchanged.
- Core store `core_a=3`, `core_wd=0xDEADBEEF` → `mem_we=1` only in the `core_gnt` cycle, no `core_rvalid`, and readback returns 0xDEADBEEF.
